// File: rtl/hc_tile_if.sv
// hc_tile_if: valid/ready tile stream carrying lane data, tile index and last marker
interface hc_tile_if #(
  parameter int N   = 16,
  parameter int DW  = 16,
  parameter int TIW = 4
);
  logic            tile_valid;
  logic            tile_ready;
  logic            tile_last;
  logic [N*DW-1:0] tile_data;
  logic [TIW-1:0]  tile_idx;
  modport master(output tile_valid, tile_data, tile_idx, tile_last, input tile_ready);
  modport slave(input tile_valid, tile_data, tile_idx, tile_last, output tile_ready);
endinterface

// File: rtl/hc_tile_streamer.sv
// hc_tile_streamer: snapshots a flat hC vector and streams it out one N-lane tile per beat
module hc_tile_streamer #(
  parameter int B  = 1,
  parameter int H  = 4,
  parameter int P  = 4,
  parameter int N  = 16,
  parameter int DW = 16,
  localparam int TILES = B*H*P,
  localparam int TIW   = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILES*N*DW-1:0] hC_flat,
  output logic                  busy,
  output logic                  done,
  hc_tile_if.master             tile
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nxt;
  logic [TILES-1:0][N*DW-1:0] snap;
  logic [TIW-1:0] idx;
  logic last, hs;
  assign last = idx == TIW'(TILES-1);
  assign hs   = state == STREAM && tile.tile_ready;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? STREAM : IDLE) : (hs && last ? IDLE : STREAM);
  // Data is a mux of the snapshot by the registered index, so it holds through stalls.
  always_comb begin
    busy            = state == STREAM;
    tile.tile_valid = busy;
    tile.tile_last  = busy && last;
    tile.tile_idx   = idx;
    tile.tile_data  = '0;
    for (int t = 0; t < TILES; t++)
      if (idx == TIW'(t)) tile.tile_data = snap[t];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      idx  <= '0;
      done <= 1'b0;
    end else begin
      done <= hs && last;
      if (state == IDLE && start) begin
        snap <= hC_flat;
        idx  <= '0;
      end else if (hs) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hc_tile_streamer.sv
// tb_hc_tile_streamer: scoreboard bench for the default 16-tile streamer and a 1-tile variant
module tb_hc_tile_streamer;
  localparam int N = 16, DW = 16, TILES = 16, TIW = 4;
  typedef struct {
    logic [TIW-1:0]  idx;
    logic [N*DW-1:0] data;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, start1, busy, done, busy1, done1;
  logic [TILES*N*DW-1:0] hc;
  logic [N*DW-1:0] hc1;
  exp_t q[$];
  exp_t q1[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  hc_tile_if #(.N(N), .DW(DW), .TIW(TIW)) s();
  hc_tile_if #(.N(N), .DW(DW), .TIW(1)) s1();

  hc_tile_streamer #(.B(1), .H(4), .P(4), .N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .hC_flat(hc), .busy(busy), .done(done), .tile(s.master)
  );
  hc_tile_streamer #(.B(1), .H(1), .P(1), .N(N), .DW(DW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hC_flat(hc1), .busy(busy1), .done(done1), .tile(s1.master)
  );

  function automatic logic [N*DW-1:0] tile_model(int t);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(t*N + i);
    return d;
  endfunction

  task automatic set_pattern();
    for (int g = 0; g < TILES*N; g++) hc[g*DW +: DW] = DW'(g);
  endtask

  task automatic push_run();
    for (int t = 0; t < TILES; t++) q.push_back('{idx: TIW'(t), data: tile_model(t), last: t == TILES-1});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start1 = 1'b1;
    s.tile_ready = 1'b1; s1.tile_ready = 1'b1;
    set_pattern();
    hc1 = tile_model(0);
    repeat (3) @(negedge clk);
    tests++;
    if ({s.tile_valid, busy, s.tile_last, done, s.tile_idx, s.tile_data} !== '0) begin
      fails++; $display("FAIL reset_main got v=%b b=%b l=%b d=%b idx=%0d data=%h want all 0",
        s.tile_valid, busy, s.tile_last, done, s.tile_idx, s.tile_data);
    end
    tests++;
    if ({s1.tile_valid, busy1, s1.tile_last, done1, s1.tile_idx, s1.tile_data} !== '0) begin
      fails++; $display("FAIL reset_single got v=%b b=%b d=%b data=%h want all 0",
        s1.tile_valid, busy1, done1, s1.tile_data);
    end
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({s.tile_valid, busy, done} !== 3'b000) begin
      fails++; $display("FAIL reset_idle got v=%b b=%b d=%b want 000", s.tile_valid, busy, done);
    end
  endtask

  task automatic test_full_rate();
    set_pattern(); q.delete();
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) @(negedge clk);
      start = c == 0; s.tile_ready = 1'b1;
      if (c == 0) push_run();
      tests++;
      if ({s.tile_valid, busy, s.tile_last, done} !== {c >= 1 && c <= 16, c >= 1 && c <= 16, c == 16, c == 17}) begin
        fails++; $display("FAIL full_rate_ctl c=%0d got vbld=%b%b%b%b want %b%b%b%b", c, s.tile_valid, busy, s.tile_last, done,
          c >= 1 && c <= 16, c >= 1 && c <= 16, c == 16, c == 17);
      end
      if (s.tile_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL full_rate_beat c=%0d got idx=%0d want no beat", c, s.tile_idx);
        end else if ({s.tile_idx, s.tile_data, s.tile_last} !== {q[0].idx, q[0].data, q[0].last}) begin
          fails++; $display("FAIL full_rate_beat c=%0d got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
            c, s.tile_idx, s.tile_last, s.tile_data, q[0].idx, q[0].last, q[0].data);
        end
        if (s.tile_ready && q.size() > 0) void'(q.pop_front());
      end
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL full_rate_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_backpressure();
    set_pattern(); q.delete();
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      start = c == 0; s.tile_ready = (c % 2) == 1;
      if (c == 0) push_run();
      tests++;
      if ({s.tile_valid, busy, s.tile_last, done} !== {c >= 1 && c <= 31, c >= 1 && c <= 31, c == 30 || c == 31, c == 32}) begin
        fails++; $display("FAIL backpressure_ctl c=%0d got vbld=%b%b%b%b want %b%b%b%b", c, s.tile_valid, busy, s.tile_last, done,
          c >= 1 && c <= 31, c >= 1 && c <= 31, c == 30 || c == 31, c == 32);
      end
      if (s.tile_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL backpressure_beat c=%0d got idx=%0d want no beat", c, s.tile_idx);
        end else if ({s.tile_idx, s.tile_data, s.tile_last} !== {q[0].idx, q[0].data, q[0].last}) begin
          fails++; $display("FAIL backpressure_beat c=%0d got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
            c, s.tile_idx, s.tile_last, s.tile_data, q[0].idx, q[0].last, q[0].data);
        end
        if (s.tile_ready && q.size() > 0) void'(q.pop_front());
      end
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL backpressure_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_ignore_start();
    set_pattern(); q.delete();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start = c == 0 || c == 5; s.tile_ready = 1'b1;
      if (c == 0) push_run();
      if (c == 2) hc = '1;
      tests++;
      if ({s.tile_valid, s.tile_last, done} !== {c >= 1 && c <= 16, c == 16, c == 17}) begin
        fails++; $display("FAIL ignore_start_ctl c=%0d got vld=%b%b%b want %b%b%b", c, s.tile_valid, s.tile_last, done,
          c >= 1 && c <= 16, c == 16, c == 17);
      end
      if (s.tile_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL ignore_start_beat c=%0d got idx=%0d want no beat", c, s.tile_idx);
        end else if ({s.tile_idx, s.tile_data, s.tile_last} !== {q[0].idx, q[0].data, q[0].last}) begin
          fails++; $display("FAIL ignore_start_beat c=%0d got idx=%0d data=%h want idx=%0d data=%h",
            c, s.tile_idx, s.tile_data, q[0].idx, q[0].data);
        end
        if (s.tile_ready && q.size() > 0) void'(q.pop_front());
      end
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL ignore_start_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_mid_reset();
    set_pattern(); q.delete();
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      start = c == 0 || c == 9; rst = c == 6; s.tile_ready = 1'b1;
      if (c == 0 || c == 9) push_run();
      tests++;
      if ({s.tile_valid, busy, s.tile_last, done} !== {(c >= 1 && c <= 6) || (c >= 10 && c <= 25),
                                                       (c >= 1 && c <= 6) || (c >= 10 && c <= 25), c == 25, c == 26}) begin
        fails++; $display("FAIL mid_reset_ctl c=%0d got vbld=%b%b%b%b", c, s.tile_valid, busy, s.tile_last, done);
      end
      if (c == 7) begin
        tests++;
        if ({s.tile_valid, busy, s.tile_last, done, s.tile_idx, s.tile_data} !== '0) begin
          fails++; $display("FAIL mid_reset_zero got v=%b b=%b d=%b idx=%0d data=%h want all 0",
            s.tile_valid, busy, done, s.tile_idx, s.tile_data);
        end
      end
      if (s.tile_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL mid_reset_beat c=%0d got idx=%0d want no beat", c, s.tile_idx);
        end else if ({s.tile_idx, s.tile_data, s.tile_last} !== {q[0].idx, q[0].data, q[0].last}) begin
          fails++; $display("FAIL mid_reset_beat c=%0d got idx=%0d data=%h want idx=%0d data=%h",
            c, s.tile_idx, s.tile_data, q[0].idx, q[0].data);
        end
        if (s.tile_ready && q.size() > 0) void'(q.pop_front());
      end
      if (c == 6) q.delete();
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL mid_reset_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    set_pattern(); q.delete();
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      start = c == 0 || c == 17; s.tile_ready = 1'b1;
      if (c == 0 || c == 17) push_run();
      tests++;
      if ({s.tile_valid, s.tile_last, done} !== {(c >= 1 && c <= 16) || (c >= 18 && c <= 33),
                                                 c == 16 || c == 33, c == 17 || c == 34}) begin
        fails++; $display("FAIL back_to_back_ctl c=%0d got vld=%b%b%b", c, s.tile_valid, s.tile_last, done);
      end
      if (s.tile_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL back_to_back_beat c=%0d got idx=%0d want no beat", c, s.tile_idx);
        end else if ({s.tile_idx, s.tile_data, s.tile_last} !== {q[0].idx, q[0].data, q[0].last}) begin
          fails++; $display("FAIL back_to_back_beat c=%0d got idx=%0d data=%h want idx=%0d data=%h",
            c, s.tile_idx, s.tile_data, q[0].idx, q[0].data);
        end
        if (s.tile_ready && q.size() > 0) void'(q.pop_front());
      end
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL back_to_back_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_single_tile();
    hc1 = tile_model(0); q1.delete();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      start1 = c == 0; s1.tile_ready = c >= 4;
      if (c == 0) q1.push_back('{idx: '0, data: tile_model(0), last: 1'b1});
      tests++;
      if ({s1.tile_valid, busy1, s1.tile_last, done1} !== {c >= 1 && c <= 4, c >= 1 && c <= 4, c >= 1 && c <= 4, c == 5}) begin
        fails++; $display("FAIL single_tile_ctl c=%0d got vbld=%b%b%b%b", c, s1.tile_valid, busy1, s1.tile_last, done1);
      end
      if (s1.tile_valid) begin
        tests++;
        if (q1.size() == 0) begin
          fails++; $display("FAIL single_tile_beat c=%0d got idx=%0d want no beat", c, s1.tile_idx);
        end else if ({TIW'(s1.tile_idx), s1.tile_data, s1.tile_last} !== {q1[0].idx, q1[0].data, q1[0].last}) begin
          fails++; $display("FAIL single_tile_beat c=%0d got idx=%0d data=%h want idx=%0d data=%h",
            c, s1.tile_idx, s1.tile_data, q1[0].idx, q1[0].data);
        end
        if (s1.tile_ready && q1.size() > 0) void'(q1.pop_front());
      end
    end
    tests++;
    if (q1.size() != 0) begin fails++; $display("FAIL single_tile_drain got %0d left want 0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_single_tile();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
